// File: rtl/dual_edge_ff_checker.sv
// Purpose : reference-model checker for a dual-edge flop (rise: q=d, fall: q=~d), sampled on clk.
// Latency : obs_clk change -> exp_q in 1 cycle; obs_clk change -> check_valid in SETTLE+1 cycles.
// Backpr. : none; an edge arriving before the pending compare abandons it and sets ovr_sticky.
//
// Ports:
//   clk, reset_l           system clock, async active-low reset
//   en, clear              enable checking; sync clear of counters/stickies/model
//   obs_clk, obs_d, obs_q  observed flop clock, data and output (already synchronous to clk)
//   exp_q                  registered model output
//   check_valid, mismatch  one-cycle compare pulse and its result
//   err_sticky, ovr_sticky sticky mismatch / overrun flags
//   edge_cnt, err_cnt      saturating edge and mismatch counters
// SETTLE must be in 1..15 (settle counter is 4 bits, and 0 would leave no compare cycle).
module dual_edge_ff_checker #(
    parameter bit INIT_Q = 1'b1,
    parameter int CNT_W  = 16,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             en,
    input  logic             clear,
    input  logic             obs_clk,
    input  logic             obs_d,
    input  logic             obs_q,
    output logic             exp_q,
    output logic             check_valid,
    output logic             mismatch,
    output logic             err_sticky,
    output logic             ovr_sticky,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, PRIME, RUN, WAIT} state_t;

    localparam logic [3:0]       SETTLE_LD = 4'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic             prev_clk, prev_nxt;
    logic [3:0]       settle_cnt, settle_nxt;
    logic             exp_nxt, cv_nxt, mm_nxt, err_st_nxt, ovr_st_nxt;
    logic [CNT_W-1:0] edge_cnt_nxt, err_cnt_nxt;
    logic             obs_edge;

    assign obs_edge = (obs_clk != prev_clk);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state       <= IDLE;
            prev_clk    <= 1'b0;
            settle_cnt  <= '0;
            exp_q       <= INIT_Q;
            check_valid <= 1'b0;
            mismatch    <= 1'b0;
            err_sticky  <= 1'b0;
            ovr_sticky  <= 1'b0;
            edge_cnt    <= '0;
            err_cnt     <= '0;
        end else begin
            state       <= state_nxt;
            prev_clk    <= prev_nxt;
            settle_cnt  <= settle_nxt;
            exp_q       <= exp_nxt;
            check_valid <= cv_nxt;
            mismatch    <= mm_nxt;
            err_sticky  <= err_st_nxt;
            ovr_sticky  <= ovr_st_nxt;
            edge_cnt    <= edge_cnt_nxt;
            err_cnt     <= err_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        prev_nxt     = prev_clk;
        settle_nxt   = settle_cnt;
        exp_nxt      = exp_q;
        cv_nxt       = 1'b0;
        mm_nxt       = 1'b0;
        err_st_nxt   = err_sticky;
        ovr_st_nxt   = ovr_sticky;
        edge_cnt_nxt = edge_cnt;
        err_cnt_nxt  = err_cnt;

        if (clear) begin
            // Clear wins over any edge or compare landing in the same cycle.
            edge_cnt_nxt = '0;
            err_cnt_nxt  = '0;
            err_st_nxt   = 1'b0;
            ovr_st_nxt   = 1'b0;
            exp_nxt      = INIT_Q;
            state_nxt    = en ? PRIME : IDLE;
        end else if (!en) begin
            // Pending compare is dropped; model, counters and stickies hold.
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = PRIME;
                PRIME: begin
                    // Resync prev_clk so a stale value cannot look like an edge.
                    prev_nxt  = obs_clk;
                    state_nxt = RUN;
                end
                RUN, WAIT: begin
                    prev_nxt = obs_clk;
                    if (state == WAIT) begin
                        if (settle_cnt == 4'd0) begin
                            // Compare uses exp_q before any same-cycle edge updates it.
                            cv_nxt    = 1'b1;
                            mm_nxt    = (obs_q != exp_q);
                            state_nxt = RUN;
                            if (obs_q != exp_q) begin
                                err_st_nxt = 1'b1;
                                if (err_cnt != CNT_MAX) err_cnt_nxt = err_cnt + CNT_ONE;
                            end
                        end else begin
                            settle_nxt = settle_cnt - 4'd1;
                        end
                    end
                    if (obs_edge) begin
                        // Only an edge that cuts a compare short counts as overrun.
                        if ((state == WAIT) && (settle_cnt != 4'd0)) ovr_st_nxt = 1'b1;
                        exp_nxt    = prev_clk ? ~obs_d : obs_d;
                        settle_nxt = SETTLE_LD;
                        state_nxt  = WAIT;
                        if (edge_cnt != CNT_MAX) edge_cnt_nxt = edge_cnt + CNT_ONE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule
